// File: rtl/inst_queue_pkg.sv
// Shared definitions for the instruction queue: the bubble encoding and the
// rule that decides which DEPTH values are legal.
package inst_queue_pkg;

  localparam logic [31:0] NOP_INST  = 32'h0;
  localparam int          DEPTH_MIN = 2;
  localparam int          DEPTH_MAX = 16;

  // Pointers wrap modulo DEPTH, so DEPTH must be a power of two.
  function automatic bit depth_legal(input int depth);
    return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/iq_ram.sv
// Entry storage for the instruction queue.
// It has one write port and one asynchronous read port.
module iq_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the memory is deliberately not reset. Occupancy lives in the
  // pointers, so stale words are never observable.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_queue.sv
// This is the fetch-to-decode instruction queue: a circular buffer of {inst, pc} entries.
// It has an optional empty-queue bypass and a one-cycle bubble after a flush.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1,
  parameter int XLEN   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fc_Icache_data_valid_i,
  input  logic [XLEN-1:0]          Icache_inst_i,
  input  logic [XLEN-1:0]          if_pc_i,
  output logic                     iq_ready_o,
  output logic                     iq_valid_o,
  output logic [XLEN-1:0]          iq_inst_o,
  output logic [XLEN-1:0]          iq_pc_o,
  input  logic                     id_ready_i,
  input  logic                     fc_flush_i,
  output logic [$clog2(DEPTH):0]   iq_count_o
);

  localparam int              AW   = $clog2(DEPTH);
  localparam int              CW   = AW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("inst_queue: DEPTH must be a power of two in 2..16");
  end

  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_bubble;
  logic              w_empty;
  logic              w_full;
  logic              w_bypass;
  logic              w_ready;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;
  logic [2*XLEN-1:0] w_rdata;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL);
  assign w_bypass = (BYPASS != 0) && w_empty;

  // rst_n is active-high here. While it is asserted, every output reads as idle.
  assign w_ready = !rst_n && (!w_full || id_ready_i);
  assign w_valid = !rst_n && !fc_flush_i && !r_bubble &&
                   (!w_empty || (w_bypass && fc_Icache_data_valid_i));
  assign w_push  = fc_Icache_data_valid_i && w_ready && !fc_flush_i;
  assign w_pop   = w_valid && id_ready_i;

  // A bypassed-and-popped entry is still written, but rptr advances past it in
  // the same cycle. This means it is never read back.
  iq_ram #(.DEPTH(DEPTH), .WIDTH(2 * XLEN)) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata ({if_pc_i, Icache_inst_i}),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    iq_inst_o = XLEN'(NOP_INST);
    iq_pc_o   = '0;
    if (w_valid) begin
      if (w_empty) begin
        iq_inst_o = Icache_inst_i;
        iq_pc_o   = if_pc_i;
      end else begin
        iq_inst_o = w_rdata[XLEN-1:0];
        iq_pc_o   = w_rdata[2*XLEN-1:XLEN];
      end
    end
  end

  assign iq_ready_o = w_ready;
  assign iq_valid_o = w_valid;
  assign iq_count_o = rst_n ? '0 : r_count;

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_bubble <= 1'b0;
    end else if (fc_flush_i) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_bubble <= 1'b1;
    end else begin
      r_bubble <= 1'b0;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue. Both variants share one stimulus stream:
// one has BYPASS=0 (a_*) and the other has BYPASS=1 (b_*), and both use DEPTH=4.
`timescale 1ns/1ps
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        id_rdy;
  logic        flush;

  logic        a_ready, a_valid, b_ready, b_valid;
  logic [31:0] a_inst, a_pc, b_inst, b_pc;
  logic [2:0]  a_count, b_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(4), .BYPASS(0), .XLEN(32)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .fc_Icache_data_valid_i(vld), .Icache_inst_i(inst),
    .if_pc_i(pc), .iq_ready_o(a_ready), .iq_valid_o(a_valid), .iq_inst_o(a_inst),
    .iq_pc_o(a_pc), .id_ready_i(id_rdy), .fc_flush_i(flush), .iq_count_o(a_count)
  );

  inst_queue #(.DEPTH(4), .BYPASS(1), .XLEN(32)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .fc_Icache_data_valid_i(vld), .Icache_inst_i(inst),
    .if_pc_i(pc), .iq_ready_o(b_ready), .iq_valid_o(b_valid), .iq_inst_o(b_inst),
    .iq_pc_o(b_pc), .id_ready_i(id_rdy), .fc_flush_i(flush), .iq_count_o(b_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Apply push-side inputs, then let the combinational paths settle.
  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
    vld  = v;
    inst = i;
    pc   = p;
    #1;
  endtask

  logic [31:0] q_inst [5] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003,
                              32'hD0D0_0004, 32'hE0E0_0005};
  logic [31:0] q_pc   [5] = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008,
                              32'h0000_100C, 32'h0000_1010};

  initial begin
    rst_n = 1'b1; id_rdy = 1'b0; flush = 1'b0;
    drive(1'b0, '0, '0);
    cyc();
    // A push presented during reset must not be accepted or bypassed.
    drive(1'b1, 32'h1111_1111, 32'h2222_2222);
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_a_count", 32'(a_count), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_b_inst",  b_inst,       32'd0);
    check("rst_b_pc",    b_pc,         32'd0);
    cyc();
    drive(1'b0, '0, '0);
    rst_n = 1'b0;
    cyc();
    check("idle_a_ready", 32'(a_ready), 32'd1);
    check("idle_a_valid", 32'(a_valid), 32'd0);
    check("idle_a_count", 32'(a_count), 32'd0);

    // Fill with A..D while decode stalls. Data shows one cycle after the push.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, q_inst[i], q_pc[i]);
      cyc();
      if (i == 0) check("lat_a_inst", a_inst, q_inst[0]);
    end
    check("full_a_count", 32'(a_count), 32'd4);
    check("full_a_ready", 32'(a_ready), 32'd0);
    drive(1'b1, q_inst[4], q_pc[4]);
    check("refuse_a_ready", 32'(a_ready), 32'd0);
    cyc();
    check("refuse_a_count", 32'(a_count), 32'd4);
    check("refuse_a_head",  a_inst,       q_inst[0]);

    // A full queue accepts E in the same cycle that A is popped.
    id_rdy = 1'b1;
    #1;
    check("fullpop_a_ready", 32'(a_ready), 32'd1);
    check("fullpop_a_head",  a_inst,       q_inst[0]);
    check("fullpop_a_pc",    a_pc,         q_pc[0]);
    cyc();
    check("fullpop_a_count", 32'(a_count), 32'd4);
    drive(1'b0, '0, '0);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("drain_a_inst%0d", i), a_inst, q_inst[i]);
      check($sformatf("drain_a_pc%0d", i),   a_pc,   q_pc[i]);
      cyc();
    end
    check("drain_a_count", 32'(a_count), 32'd0);
    check("drain_a_valid", 32'(a_valid), 32'd0);

    // Bypass: an empty queue hands the push straight through and stores nothing.
    drive(1'b1, 32'h0050_0093, 32'h0000_0200);
    check("byp_b_valid", 32'(b_valid), 32'd1);
    check("byp_b_inst",  b_inst,       32'h0050_0093);
    check("byp_b_pc",    b_pc,         32'h0000_0200);
    check("byp_a_valid", 32'(a_valid), 32'd0);
    cyc();
    drive(1'b0, '0, '0);
    check("byp_b_count", 32'(b_count), 32'd0);
    check("byp_a_inst",  a_inst,       32'h0050_0093);
    cyc();
    cyc();

    // Reach count=3 in the bypass queue, then flush while a push and a pop are both requested.
    id_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, q_inst[i], q_pc[i]);
      cyc();
    end
    check("pre_flush_b_count", 32'(b_count), 32'd3);
    flush = 1'b1; id_rdy = 1'b1;
    drive(1'b1, q_inst[3], q_pc[3]);
    check("flush_b_valid", 32'(b_valid), 32'd0);
    check("flush_b_inst",  b_inst,       32'd0);
    cyc();
    flush = 1'b0;
    drive(1'b1, 32'h0000_0513, 32'h0000_0300);
    check("post_flush_b_count", 32'(b_count), 32'd0);
    check("bubble_b_valid",     32'(b_valid), 32'd0);
    cyc();
    drive(1'b1, 32'h0010_0593, 32'h0000_0304);
    check("deliver_b_valid", 32'(b_valid), 32'd1);
    check("deliver_b_inst",  b_inst,       32'h0000_0513);
    cyc();
    drive(1'b0, '0, '0);
    check("deliver2_b_inst", b_inst, 32'h0010_0593);
    cyc();
    check("deliver_b_count", 32'(b_count), 32'd0);

    // A stalled head must hold its value across the whole stall.
    id_rdy = 1'b0;
    drive(1'b1, 32'h00C5_8633, 32'h0000_0400);
    cyc();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_a_inst%0d", i), a_inst, 32'h00C5_8633);
      check($sformatf("stall_a_cnt%0d", i),  32'(a_count), 32'd1);
      cyc();
    end
    id_rdy = 1'b1;
    cyc();
    check("stall_a_popped", 32'(a_count), 32'd0);

    // Reset with two entries queued. The old entries must never come back.
    id_rdy = 1'b0;
    drive(1'b1, 32'hDEAD_0001, 32'h0000_0500);
    cyc();
    drive(1'b1, 32'hDEAD_0002, 32'h0000_0504);
    cyc();
    drive(1'b0, '0, '0);
    check("prerst_a_count", 32'(a_count), 32'd2);
    rst_n = 1'b1;
    #1;
    check("midrst_a_valid", 32'(a_valid), 32'd0);
    check("midrst_a_inst",  a_inst,       32'd0);
    check("midrst_a_pc",    a_pc,         32'd0);
    check("midrst_a_count", 32'(a_count), 32'd0);
    check("midrst_a_ready", 32'(a_ready), 32'd0);
    cyc();
    rst_n = 1'b0;
    #1;
    check("postrst_a_valid", 32'(a_valid), 32'd0);
    check("postrst_a_count", 32'(a_count), 32'd0);
    drive(1'b1, 32'h0000_0013, 32'h0000_0600);
    cyc();
    drive(1'b0, '0, '0);
    check("postrst_a_head",  a_inst,       32'h0000_0013);
    check("postrst_a_cnt1",  32'(a_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
